temporal_buffer_stream: RTL and testbench

Multi-slot successor to the temporal buffer array in the SAT local-search datapath. It captures, per candidate flip, the flipped literal plus up to MAX_CLAUSES_PER_VARIABLE partner-literal sets read from the clause table. Once the heuristic selector picks a slot, it streams that slot's clauses out one per cycle over a valid/ready handshake, instead of presenting the full wide bus at once. Writes to other slots may continue during a drain, so the next round's candidates overlap with the current round's clause update.

---
 rtl/temporal_buffer_stream_if.sv | 64 ++++++
 rtl/temporal_buffer_stream.sv | 208 ++++++++++++++++++++
 tb/tb_temporal_buffer_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temporal_buffer_stream_if.sv
// temporal_buffer_stream_if
//   Groups the write, selection and clause-stream signals of the
//   temporal_buffer_stream block into one bundle.
//   slave  : view used by the buffer itself
//   master : view used by the producer / selector / stream consumer
// Signals:
//   flush_i                         synchronous clear of all slots
//   wr_valid_i, wr_slot_i,
//   wr_count_i, flipped_literal_i,
//   clause_table_literals_multi_i,
//   broken_mask_i                   slot write port
//   wr_drop_o                       pulse: write discarded (target draining)
//   sel_valid_i, sel_slot_i,
//   sel_ready_o                     slot selection handshake
//   busy_o                          drain in progress
//   clause_valid_o, clause_ready_i,
//   clause_o, clause_index_o,
//   clause_last_o                   clause stream
//   done_o                          pulse: drain complete
interface temporal_buffer_stream_if #(
  parameter int NSAT                     = 3,
  parameter int LITERAL_ADDRESS_WIDTH    = 11,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NUM_SLOTS                = 4,
  parameter int SLOT_BITS                = 2,
  parameter int COUNT_BITS               = 5
);
  localparam int LW = LITERAL_ADDRESS_WIDTH + 1;

  logic                                             flush_i;
  logic                                             wr_valid_i;
  logic [SLOT_BITS-1:0]                             wr_slot_i;
  logic [COUNT_BITS-1:0]                            wr_count_i;
  logic [LW-1:0]                                    flipped_literal_i;
  logic [(NSAT-1)*MAX_CLAUSES_PER_VARIABLE*LW-1:0]  clause_table_literals_multi_i;
  logic [MAX_CLAUSES_PER_VARIABLE-1:0]              broken_mask_i;
  logic                                             wr_drop_o;
  logic                                             sel_valid_i;
  logic [SLOT_BITS-1:0]                             sel_slot_i;
  logic                                             sel_ready_o;
  logic                                             busy_o;
  logic                                             clause_valid_o;
  logic                                             clause_ready_i;
  logic [NSAT*LW-1:0]                               clause_o;
  logic [COUNT_BITS-1:0]                            clause_index_o;
  logic                                             clause_last_o;
  logic                                             done_o;

  modport slave (
    input  flush_i, wr_valid_i, wr_slot_i, wr_count_i, flipped_literal_i,
           clause_table_literals_multi_i, broken_mask_i,
           sel_valid_i, sel_slot_i, clause_ready_i,
    output wr_drop_o, sel_ready_o, busy_o, clause_valid_o, clause_o,
           clause_index_o, clause_last_o, done_o
  );

  modport master (
    output flush_i, wr_valid_i, wr_slot_i, wr_count_i, flipped_literal_i,
           clause_table_literals_multi_i, broken_mask_i,
           sel_valid_i, sel_slot_i, clause_ready_i,
    input  wr_drop_o, sel_ready_o, busy_o, clause_valid_o, clause_o,
           clause_index_o, clause_last_o, done_o
  );
endinterface

// File: rtl/temporal_buffer_stream.sv
// temporal_buffer_stream
//   Multi-slot capture buffer for candidate flips. Each slot holds a flipped
//   literal plus up to MAX_CLAUSES_PER_VARIABLE partner-literal entries. A
//   selected slot is streamed out one clause per cycle over valid/ready while
//   other slots keep accepting writes.
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    temporal_buffer_stream_if.slave (write, select, stream signals)
// Optional feature macro: TB_BROKEN_ONLY_EN
//   defined   : only entries with index < count and broken_mask bit set are emitted
//   undefined : broken_mask_i is ignored, every index < count is emitted
module temporal_buffer_stream #(
  parameter int NSAT                     = 3,
  parameter int LITERAL_ADDRESS_WIDTH    = 11,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NUM_SLOTS                = 4,
  parameter int SLOT_BITS                = 2,
  parameter int COUNT_BITS               = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  temporal_buffer_stream_if.slave  bus
);
  localparam int LW   = LITERAL_ADDRESS_WIDTH + 1;
  localparam int EW   = (NSAT - 1) * LW;
  localparam int MCPV = MAX_CLAUSES_PER_VARIABLE;
  localparam logic [COUNT_BITS-1:0] MCPV_C = COUNT_BITS'(MCPV);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   slot_valid_q, slot_valid_d;
  logic [SLOT_BITS-1:0]   drain_slot_q, drain_slot_d;
  logic [COUNT_BITS-1:0]  cursor_q, cursor_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;

  logic [LW-1:0]          flip_q  [NUM_SLOTS];
  logic [EW-1:0]          entry_q [NUM_SLOTS][MCPV];
  logic [COUNT_BITS-1:0]  count_q [NUM_SLOTS];
`ifdef TB_BROKEN_ONLY_EN
  logic [MCPV-1:0]        mask_q  [NUM_SLOTS];
`else
  logic                   unused_mask_s;
  assign unused_mask_s = ^bus.broken_mask_i;
`endif

  logic [MCPV-1:0]        em_sel_s;
  logic [MCPV-1:0]        em_drain_s;
  logic [COUNT_BITS:0]    first_sel_s;
  logic [COUNT_BITS:0]    next_drain_s;
  logic                   sel_ready_s;
  logic                   wr_accept_s;
  logic [COUNT_BITS-1:0]  wr_count_clamped_s;

  // Lowest set bit of v at or above 'from'; MSB of the result is the found flag.
  function automatic logic [COUNT_BITS:0] find_from(input logic [MCPV-1:0] v,
                                                    input logic [COUNT_BITS-1:0] from);
    logic [COUNT_BITS:0] r;
    r = '0;
    for (int i = MCPV - 1; i >= 0; i--) begin
      if (v[i] && (COUNT_BITS'(i) >= from)) begin
        r = {1'b1, COUNT_BITS'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Emittable-entry vectors for the slot being selected and the slot being drained.
  always_comb begin
    em_sel_s   = '0;
    em_drain_s = '0;
    for (int i = 0; i < MCPV; i++) begin
      em_sel_s[i]   = (COUNT_BITS'(i) < count_q[bus.sel_slot_i]);
      em_drain_s[i] = (COUNT_BITS'(i) < count_q[drain_slot_q]);
`ifdef TB_BROKEN_ONLY_EN
      em_sel_s[i]   = em_sel_s[i]   & mask_q[bus.sel_slot_i][i];
      em_drain_s[i] = em_drain_s[i] & mask_q[drain_slot_q][i];
`endif
    end
  end

  assign first_sel_s        = find_from(em_sel_s, '0);
  assign next_drain_s       = find_from(em_drain_s, cursor_q + COUNT_BITS'(1));
  assign wr_count_clamped_s = (bus.wr_count_i > MCPV_C) ? MCPV_C : bus.wr_count_i;

  // A same-cycle write to the requested slot blocks selection so the drain
  // never starts on half-updated contents.
  assign sel_ready_s = (state_q == ST_IDLE) && !bus.flush_i &&
                       !(bus.wr_valid_i && (bus.wr_slot_i == bus.sel_slot_i));

  // Next-state logic: flush dominates, then writes, then FSM transitions.
  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    drain_slot_d = drain_slot_q;
    cursor_d     = cursor_q;
    done_d       = 1'b0;
    drop_d       = 1'b0;
    wr_accept_s  = 1'b0;

    if (bus.flush_i) begin
      slot_valid_d = '0;
      state_d      = ST_IDLE;
    end else begin
      if (bus.wr_valid_i) begin
        if ((state_q == ST_DRAIN) && (bus.wr_slot_i == drain_slot_q)) begin
          drop_d = 1'b1;
        end else begin
          wr_accept_s                 = 1'b1;
          slot_valid_d[bus.wr_slot_i] = 1'b1;
        end
      end else begin
        wr_accept_s = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.sel_valid_i && sel_ready_s) begin
            if (slot_valid_q[bus.sel_slot_i] && first_sel_s[COUNT_BITS]) begin
              state_d      = ST_DRAIN;
              drain_slot_d = bus.sel_slot_i;
              cursor_d     = first_sel_s[COUNT_BITS-1:0];
            end else begin
              done_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (bus.clause_ready_i) begin
            if (next_drain_s[COUNT_BITS]) begin
              cursor_d = next_drain_s[COUNT_BITS-1:0];
            end else begin
              slot_valid_d[drain_slot_q] = 1'b0;
              state_d                    = ST_IDLE;
              done_d                     = 1'b1;
            end
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      slot_valid_q <= '0;
      drain_slot_q <= '0;
      cursor_q     <= '0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      drain_slot_q <= drain_slot_d;
      cursor_q     <= cursor_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
    end
  end

  // Slot payload storage, loaded on an accepted write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        flip_q[s]  <= '0;
        count_q[s] <= '0;
`ifdef TB_BROKEN_ONLY_EN
        mask_q[s]  <= '0;
`endif
        for (int e = 0; e < MCPV; e++) begin
          entry_q[s][e] <= '0;
        end
      end
    end else if (wr_accept_s) begin
      flip_q[bus.wr_slot_i]  <= bus.flipped_literal_i;
      count_q[bus.wr_slot_i] <= wr_count_clamped_s;
`ifdef TB_BROKEN_ONLY_EN
      mask_q[bus.wr_slot_i]  <= bus.broken_mask_i;
`endif
      for (int e = 0; e < MCPV; e++) begin
        entry_q[bus.wr_slot_i][e] <= bus.clause_table_literals_multi_i[e*EW +: EW];
      end
    end
  end

  // Stream outputs come straight from registered state and are zero outside a drain.
  assign bus.sel_ready_o    = sel_ready_s;
  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.clause_valid_o = (state_q == ST_DRAIN);
  assign bus.clause_o       = (state_q == ST_DRAIN) ?
                              {entry_q[drain_slot_q][cursor_q], flip_q[drain_slot_q]} : '0;
  assign bus.clause_index_o = (state_q == ST_DRAIN) ? cursor_q : '0;
  assign bus.clause_last_o  = (state_q == ST_DRAIN) && !next_drain_s[COUNT_BITS];
  assign bus.done_o         = done_q;
  assign bus.wr_drop_o      = drop_q;
endmodule

// File: tb/tb_temporal_buffer_stream.sv
module tb_temporal_buffer_stream;
  localparam int LW   = 12;
  localparam int EW   = 24;
  localparam int MCPV = 20;

  logic clk;
  logic reset;

  temporal_buffer_stream_if bif ();

  temporal_buffer_stream dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [35:0] clause;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  int total = 0;
  int bad = 0;
  int beat_cnt = 0;
  int done_cnt = 0;

  // reference model of slot contents
  logic        m_valid [4];
  logic [11:0] m_flip  [4];
  logic [23:0] m_entry [4][MCPV];
  int          m_count [4];
  logic [19:0] m_mask  [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] gen_entry(input logic [11:0] base, input int e);
    logic [11:0] p0;
    logic [11:0] p1;
    p0 = base + 12'(2 * e + 1);
    p1 = base + 12'(2 * e + 2);
    return {p1, p0};
  endfunction

  function automatic logic [35:0] exp_clause(input int s, input int i);
    return {m_entry[s][i], m_flip[s]};
  endfunction

  function automatic bit emittable(input int s, input int i);
    bit r;
    r = (i < m_count[s]);
`ifdef TB_BROKEN_ONLY_EN
    r = r && m_mask[s][i];
`endif
    return r;
  endfunction

  // Stream monitor: every handshake is scored against the expected queue.
  always @(negedge clk) begin
    if (!reset && bif.clause_valid_o && bif.clause_ready_i) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL beat_unexpected index=%0d expected no beat", bif.clause_index_o);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_index", 64'(bif.clause_index_o), 64'(b.idx));
        check("beat_clause", 64'(bif.clause_o), 64'(b.clause));
        check("beat_last", 64'(bif.clause_last_o), 64'(b.last));
      end
    end
    if (!reset && bif.done_o) done_cnt++;
  end

  task automatic write_slot(input int s, input int cnt, input logic [11:0] base,
                            input logic [19:0] mask, input bit expect_drop);
    logic [(EW*MCPV)-1:0] tbl;
    for (int e = 0; e < MCPV; e++) tbl[e*EW +: EW] = gen_entry(base, e);
    bif.wr_valid_i = 1'b1;
    bif.wr_slot_i = 2'(s);
    bif.wr_count_i = 5'(cnt);
    bif.flipped_literal_i = base;
    bif.clause_table_literals_multi_i = tbl;
    bif.broken_mask_i = mask;
    tick();
    bif.wr_valid_i = 1'b0;
    check("wr_drop", 64'(bif.wr_drop_o), 64'(expect_drop));
    if (!expect_drop) begin
      m_valid[s] = 1'b1;
      m_flip[s]  = base;
      m_count[s] = (cnt > MCPV) ? MCPV : cnt;
      m_mask[s]  = mask;
      for (int e = 0; e < MCPV; e++) m_entry[s][e] = gen_entry(base, e);
    end
  endtask

  // Issue a selection; pushes the expected beats and returns their number.
  task automatic select_slot(input int s, output int n);
    int idxs[$];
    n = 0;
    bif.sel_valid_i = 1'b1;
    bif.sel_slot_i = 2'(s);
    #1;
    check("sel_ready", 64'(bif.sel_ready_o), 64'd1);
    if (m_valid[s]) begin
      for (int i = 0; i < MCPV; i++) if (emittable(s, i)) idxs.push_back(i);
    end
    n = idxs.size();
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.idx = 5'(idxs[k]);
      b.clause = exp_clause(s, idxs[k]);
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
    if (n > 0) m_valid[s] = 1'b0;
    tick();
    bif.sel_valid_i = 1'b0;
    if (n == 0) begin
      check("empty_sel_done", 64'(bif.done_o), 64'd1);
      check("empty_sel_novalid", 64'(bif.clause_valid_o), 64'd0);
      check("empty_sel_busy", 64'(bif.busy_o), 64'd0);
    end else begin
      check("first_beat_valid", 64'(bif.clause_valid_o), 64'd1);
      check("first_beat_index", 64'(bif.clause_index_o), 64'(idxs[0]));
    end
  endtask

  task automatic wait_done(input int budget, output int ticks);
    bit found;
    found = 1'b0;
    ticks = 0;
    for (int i = 0; i < budget; i++) begin
      if (bif.done_o) begin
        found = 1'b1;
        break;
      end
      tick();
      ticks++;
    end
    check("done_within_budget", 64'(found), 64'd1);
  endtask

  task automatic clear_model();
    for (int s = 0; s < 4; s++) m_valid[s] = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int b0;
    int d0;
    clear_model();
    for (int s = 0; s < 4; s++) begin
      m_count[s] = 0;
      m_flip[s] = '0;
      m_mask[s] = '0;
    end
    reset = 1'b1;
    bif.flush_i = 1'b0;
    bif.wr_valid_i = 1'b0;
    bif.wr_slot_i = 2'd0;
    bif.wr_count_i = 5'd0;
    bif.flipped_literal_i = 12'd0;
    bif.clause_table_literals_multi_i = '0;
    bif.broken_mask_i = 20'd0;
    bif.sel_valid_i = 1'b0;
    bif.sel_slot_i = 2'd0;
    bif.clause_ready_i = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(bif.busy_o), 64'd0);
    check("rst_valid", 64'(bif.clause_valid_o), 64'd0);
    check("rst_done", 64'(bif.done_o), 64'd0);
    check("rst_drop", 64'(bif.wr_drop_o), 64'd0);
    reset = 1'b0;
    tick();

    // basic 3-clause drain, back-to-back
    bif.clause_ready_i = 1'b1;
    write_slot(1, 3, 12'h101, 20'hFFFFF, 1'b0);
    select_slot(1, n);
    tick();
    check("t1_idx1", 64'(bif.clause_index_o), 64'd1);
    check("t1_last1", 64'(bif.clause_last_o), 64'd0);
    tick();
    check("t1_idx2", 64'(bif.clause_index_o), 64'd2);
    check("t1_last2", 64'(bif.clause_last_o), 64'd1);
    tick();
    check("t1_done", 64'(bif.done_o), 64'd1);
    check("t1_busy", 64'(bif.busy_o), 64'd0);
    tick();
    check("t1_done_pulse", 64'(bif.done_o), 64'd0);
    select_slot(1, n);  // slot 1 now invalid

    // stalls: ready 1,0,0,1 over a 2-clause drain
    write_slot(2, 2, 12'h202, 20'hFFFFF, 1'b0);
    b0 = beat_cnt;
    d0 = done_cnt;
    select_slot(2, n);
    tick();
    bif.clause_ready_i = 1'b0;
    check("t2_idx", 64'(bif.clause_index_o), 64'd1);
    check("t2_clause", 64'(bif.clause_o), 64'(exp_clause(2, 1)));
    tick();
    check("t2_hold_idx", 64'(bif.clause_index_o), 64'd1);
    check("t2_hold_clause", 64'(bif.clause_o), 64'(exp_clause(2, 1)));
    tick();
    check("t2_hold_idx2", 64'(bif.clause_index_o), 64'd1);
    check("t2_hold_last", 64'(bif.clause_last_o), 64'd1);
    bif.clause_ready_i = 1'b1;
    tick();
    check("t2_done", 64'(bif.done_o), 64'd1);
    tick();
    tick();
    check("t2_handshakes", 64'(beat_cnt - b0), 64'd2);
    check("t2_done_count", 64'(done_cnt - d0), 64'd1);

    // empty selection and same-cycle write/select collision
    select_slot(3, n);
    bif.wr_valid_i = 1'b1;
    bif.wr_slot_i = 2'd2;
    bif.wr_count_i = 5'd4;
    bif.flipped_literal_i = 12'h2A0;
    for (int e = 0; e < MCPV; e++) bif.clause_table_literals_multi_i[e*EW +: EW] = gen_entry(12'h2A0, e);
    bif.broken_mask_i = 20'hFFFFF;
    bif.sel_valid_i = 1'b1;
    bif.sel_slot_i = 2'd2;
    #1;
    check("t3_sel_blocked", 64'(bif.sel_ready_o), 64'd0);
    tick();
    bif.wr_valid_i = 1'b0;
    bif.sel_valid_i = 1'b0;
    m_valid[2] = 1'b1;
    m_flip[2] = 12'h2A0;
    m_count[2] = 4;
    m_mask[2] = 20'hFFFFF;
    for (int e = 0; e < MCPV; e++) m_entry[2][e] = gen_entry(12'h2A0, e);
    check("t3_no_stream", 64'(bif.clause_valid_o), 64'd0);

    // writes during a drain: same slot dropped, other slot accepted
    bif.clause_ready_i = 1'b0;
    write_slot(0, 5, 12'h300, 20'hFFFFF, 1'b0);
    select_slot(0, n);
    write_slot(0, 7, 12'h350, 20'hFFFFF, 1'b1);
    check("t4_sel_ignored_busy", 64'(bif.sel_ready_o), 64'd0);
    write_slot(2, 2, 12'h2C0, 20'hFFFFF, 1'b0);
    check("t4_clause_unchanged", 64'(bif.clause_o), 64'(exp_clause(0, 0)));
    bif.clause_ready_i = 1'b1;
    wait_done(30, t);
    check("t4_ticks", 64'(t), 64'(n));
    tick();
    select_slot(2, n);
    wait_done(30, t);
    check("t4b_ticks", 64'(t), 64'(n));
    tick();

    // count clamp: 31 -> 20 beats
    write_slot(1, 31, 12'h400, 20'hFFFFF, 1'b0);
    b0 = beat_cnt;
    select_slot(1, n);
    wait_done(60, t);
    check("t5_ticks", 64'(t), 64'(n));
    check("t5_beats", 64'(beat_cnt - b0), 64'd20);
    tick();

    // flush on beat 5
    write_slot(1, 31, 12'h500, 20'hFFFFF, 1'b0);
    write_slot(3, 3, 12'h600, 20'hFFFFF, 1'b0);
    d0 = done_cnt;
    select_slot(1, n);
    tick();
    tick();
    tick();
    tick();
    check("t5_beat5_idx", 64'(bif.clause_index_o), 64'd4);
    bif.flush_i = 1'b1;
    tick();
    bif.flush_i = 1'b0;
    exp_q.delete();
    clear_model();
    check("t5_flush_valid", 64'(bif.clause_valid_o), 64'd0);
    check("t5_flush_busy", 64'(bif.busy_o), 64'd0);
    tick();
    tick();
    check("t5_flush_nodone", 64'(done_cnt - d0), 64'd0);
    select_slot(3, n);
    select_slot(1, n);

    // broken-mask filtering (all entries < count emitted when disabled)
    write_slot(0, 6, 12'h700, 20'b100101, 1'b0);
    select_slot(0, n);
    wait_done(30, t);
    check("t6_ticks", 64'(t), 64'(n));
    tick();
    write_slot(3, 6, 12'h780, 20'd0, 1'b0);
    select_slot(3, n);
    wait_done(30, t);
    check("t6b_ticks", 64'(t), 64'(n));
    tick();

    // async reset mid-drain
    bif.clause_ready_i = 1'b0;
    write_slot(0, 4, 12'h800, 20'hFFFFF, 1'b0);
    write_slot(2, 4, 12'h880, 20'hFFFFF, 1'b0);
    select_slot(0, n);
    #2;
    reset = 1'b1;
    #1;
    check("t7_rst_valid", 64'(bif.clause_valid_o), 64'd0);
    check("t7_rst_busy", 64'(bif.busy_o), 64'd0);
    exp_q.delete();
    clear_model();
    tick();
    reset = 1'b0;
    tick();
    select_slot(2, n);
    tick();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit in case the design stops responding.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
